// File: rtl/axi_master_rd_pkg.sv
// Shared AXI constants and read-master FSM encoding.
// Reused by the write master and write slave so burst/response codes stay consistent.
package axi_master_rd_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_RD   = 2'd2,
    ST_DONE = 2'd3
  } rd_state_e;

endpackage

// File: rtl/axi_master_rd.sv
// AXI4 read master: one INCR burst per rd_start, beats forwarded as one-cycle rd_data_valid strobes.
// Latency: arvalid 1 clk after rd_start; each beat appears 1 clk after its R handshake.
// Backpressure: rd_start ignored unless rd_ready; rready held high in RD, R-channel gaps stall the burst.
module axi_master_rd
  import axi_master_rd_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'b0000,
  parameter int          ADDR_W = 30,
  parameter int          DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_len,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              rd_done,
  output logic              rd_err,
  output logic [3:0]        m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic [3:0]        m_axi_arqos,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [3:0]        m_axi_rid,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_W / 8));

  rd_state_e  state;
  logic [7:0] beat_cnt;
  logic       beat;
  logic       cnt_last;
  logic       beat_last;
  logic       beat_bad;

  assign m_axi_arid    = AXI_ID;
  assign m_axi_arsize  = AR_SIZE;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_DEF;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;

  assign rd_ready = (state == ST_IDLE);

  assign beat      = m_axi_rvalid & m_axi_rready;
  assign cnt_last  = (beat_cnt == m_axi_arlen);
  // Either an early rlast or reaching arlen closes the burst; any disagreement is flagged.
  assign beat_last = m_axi_rlast | cnt_last;
  assign beat_bad  = (m_axi_rresp != AXI_RESP_OKAY) | (m_axi_rid != AXI_ID) |
                     (m_axi_rlast != cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      beat_cnt      <= '0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      rd_done       <= 1'b0;
      rd_err        <= 1'b0;
    end else begin
      rd_data_valid <= 1'b0;
      rd_done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rd_start) begin
            m_axi_araddr  <= rd_addr;
            m_axi_arlen   <= rd_len;
            m_axi_arvalid <= 1'b1;
            beat_cnt      <= '0;
            rd_err        <= 1'b0;
            state         <= ST_AR;
          end
        end
        ST_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_RD;
          end
        end
        ST_RD: begin
          if (beat) begin
            rd_data       <= m_axi_rdata;
            rd_data_valid <= 1'b1;
            beat_cnt      <= beat_cnt + 8'd1;
            rd_err        <= rd_err | beat_bad;
            if (beat_last) begin
              m_axi_rready <= 1'b0;
              rd_done      <= 1'b1;
              state        <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_rd.sv
// Directed bench for axi_master_rd with a behavioural AXI read slave
// (programmable arready delay, rvalid gap pattern, data base, early rlast and error response).
module tb_axi_master_rd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_start;
  logic [29:0] rd_addr;
  logic [7:0]  rd_len;
  logic        rd_ready;
  logic [63:0] rd_data;
  logic        rd_data_valid;
  logic        rd_done;
  logic        rd_err;
  logic [3:0]  m_axi_arid;
  logic [29:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic [3:0]  m_axi_arqos;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [3:0]  m_axi_rid;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  always #5 clk = ~clk;

  axi_master_rd dut (
    .clk(clk), .rst_n(rst_n),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_done(rd_done), .rd_err(rd_err),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // Slave configuration, written only by the stimulus block.
  int          cfg_ar_delay = 0;
  logic [31:0] cfg_pat      = '0;
  int          cfg_pat_len  = 0;
  logic [63:0] cfg_base     = '0;
  int          cfg_last     = -1;
  int          cfg_err_beat = -1;
  logic [1:0]  cfg_err_resp = 2'b00;

  // Slave state and handshake log.
  int         ar_cnt;
  bit         dphase;
  int         sbeat;
  int         pcyc;
  logic [7:0] slen;
  int         n_ar = 0;
  int         n_hs = 0;
  int         hs_cyc [128];

  // Strobe log.
  int cyc    = 0;
  int n_strb = 0;
  int strb_cyc [128];

  int tot = 0;
  int bad = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dphase <= 1'b0;
      ar_cnt <= 0;
      sbeat  <= 0;
      pcyc   <= 0;
      slen   <= '0;
    end else begin
      if (m_axi_arvalid && m_axi_arready) begin
        dphase <= 1'b1;
        sbeat  <= 0;
        pcyc   <= 0;
        ar_cnt <= 0;
        slen   <= m_axi_arlen;
        n_ar   <= n_ar + 1;
      end else if (m_axi_arvalid) begin
        ar_cnt <= ar_cnt + 1;
      end
      if (dphase) begin
        pcyc <= pcyc + 1;
        if (m_axi_rvalid && m_axi_rready) begin
          if (n_hs < 128) hs_cyc[n_hs] <= cyc;
          n_hs  <= n_hs + 1;
          sbeat <= sbeat + 1;
          if (m_axi_rlast) dphase <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    int lastb;
    lastb = (cfg_last >= 0) ? cfg_last : int'(slen);
    m_axi_arready = (ar_cnt >= cfg_ar_delay);
    m_axi_rid     = 4'b0000;
    if (dphase) begin
      m_axi_rvalid = (pcyc < cfg_pat_len) ? cfg_pat[pcyc] : 1'b1;
      m_axi_rdata  = cfg_base + 64'(sbeat);
      m_axi_rlast  = (sbeat == lastb);
      m_axi_rresp  = (sbeat == cfg_err_beat) ? cfg_err_resp : 2'b00;
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rdata  = '0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_data_valid === 1'b1) begin
      if (n_strb < 128) strb_cyc[n_strb] <= cyc;
      n_strb <= n_strb + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [29:0] a, input logic [7:0] l);
    @(negedge clk);
    rd_addr  = a;
    rd_len   = l;
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
  endtask

  // Follows the burst to rd_done, checking each strobe's data and that rd_data holds in gaps.
  task automatic wait_done(input logic [63:0] base, input int nexp, input logic exp_err);
    int seen = 0;
    bit got  = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      rd_start = 1'b0;
      if (rd_data_valid === 1'b1) begin
        chk("beat_data", rd_data, base + 64'(seen));
        seen++;
      end else if (seen > 0) begin
        chk("gap_hold", rd_data, base + 64'(seen - 1));
      end
      if (rd_done === 1'b1) begin
        got = 1;
        chk("done_with_valid", rd_data_valid, 1'b1);
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("beat_count", 64'(seen), 64'(nexp));
    chk("done_err", rd_err, exp_err);
    @(negedge clk);
    chk("ready_after_done", rd_ready, 1'b1);
    chk("done_one_cycle", rd_done, 1'b0);
  endtask

  initial begin
    int sb;
    int hb;
    int ab;
    rst_n    = 1'b0;
    rd_start = 1'b0;
    rd_addr  = '0;
    rd_len   = '0;
    repeat (2) @(negedge clk);

    // Reset state and constant AR fields
    chk("rst_ready", rd_ready, 1'b1);
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_rready", m_axi_rready, 1'b0);
    chk("rst_valid", rd_data_valid, 1'b0);
    chk("rst_done", rd_done, 1'b0);
    chk("rst_err", rd_err, 1'b0);
    chk("rst_data", rd_data, 64'd0);
    chk("rst_araddr", m_axi_araddr, 64'd0);
    chk("rst_arlen", m_axi_arlen, 64'd0);
    chk("arsize", m_axi_arsize, 3'b011);
    chk("arburst", m_axi_arburst, 2'b01);
    chk("arcache", m_axi_arcache, 4'b0010);
    chk("arid", m_axi_arid, 4'b0000);
    chk("arlock_prot_qos", {m_axi_arlock, m_axi_arprot, m_axi_arqos}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", rd_ready, 1'b1);

    // Single beat: addr 4, len 0, data 0xA
    cfg_base = 64'hA;
    start(30'h4, 8'd0);
    chk("t1_arvalid", m_axi_arvalid, 1'b1);
    chk("t1_araddr", m_axi_araddr, 64'h4);
    chk("t1_arlen", m_axi_arlen, 64'd0);
    chk("t1_not_ready", rd_ready, 1'b0);
    wait_done(64'hA, 1, 1'b0);

    // Eight back-to-back beats, data 0..7
    cfg_base = 64'd0;
    sb = n_strb;
    start(30'h100, 8'd7);
    wait_done(64'd0, 8, 1'b0);
    chk("t2_nstrb", 64'(n_strb - sb), 64'd8);
    chk("t2_consecutive", 64'(strb_cyc[sb+7] - strb_cyc[sb]), 64'd7);

    // arready held low for 5 cycles
    cfg_ar_delay = 5;
    cfg_base     = 64'h40;
    ab = n_ar;
    start(30'h3FFF_FFF0, 8'd2);
    for (int i = 0; i < 5; i++) begin
      chk("t3_arvalid_hold", m_axi_arvalid, 1'b1);
      chk("t3_araddr_hold", m_axi_araddr, 64'h3FFF_FFF0);
      chk("t3_arlen_hold", m_axi_arlen, 64'd2);
      chk("t3_no_rd", m_axi_rready, 1'b0);
      if (i < 4) @(negedge clk);
    end
    wait_done(64'h40, 3, 1'b0);
    chk("t3_one_ar", 64'(n_ar - ab), 64'd1);
    cfg_ar_delay = 0;

    // rvalid pattern 1,0,0,1,1,0,1 over a 4-beat burst
    cfg_pat     = 32'h59;
    cfg_pat_len = 7;
    cfg_base    = 64'h100;
    sb = n_strb;
    hb = n_hs;
    start(30'h200, 8'd3);
    wait_done(64'h100, 4, 1'b0);
    chk("t4_nhs", 64'(n_hs - hb), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("t4_strobe_lat", 64'(strb_cyc[sb+i] - hs_cyc[hb+i]), 64'd1);
    chk("t4_hs_gap", 64'(hs_cyc[hb+1] - hs_cyc[hb]), 64'd3);
    cfg_pat_len = 0;

    // Early rlast on beat 3 with SLVERR, plus a stray rd_start mid-burst
    cfg_last     = 3;
    cfg_err_beat = 3;
    cfg_err_resp = 2'b10;
    cfg_base     = 64'h300;
    ab = n_ar;
    start(30'h300, 8'd7);
    @(negedge clk);
    rd_addr  = 30'h1234;
    rd_start = 1'b1;
    wait_done(64'h300, 4, 1'b1);
    repeat (4) @(negedge clk);
    chk("t5_no_second_ar", 64'(n_ar - ab), 64'd1);
    chk("t5_arvalid_low", m_axi_arvalid, 1'b0);
    chk("t5_araddr_kept", m_axi_araddr, 64'h300);
    cfg_last     = -1;
    cfg_err_beat = -1;

    // Reset during beat 2 of a 16-beat burst
    cfg_base = 64'h400;
    start(30'h44, 8'd15);
    repeat (3) @(negedge clk);
    chk("t6_pre_data", rd_data, 64'h401);
    rst_n = 1'b0;
    #1;
    chk("t6_ready", rd_ready, 1'b1);
    chk("t6_arvalid", m_axi_arvalid, 1'b0);
    chk("t6_rready", m_axi_rready, 1'b0);
    chk("t6_valid", rd_data_valid, 1'b0);
    chk("t6_done", rd_done, 1'b0);
    chk("t6_err", rd_err, 1'b0);
    chk("t6_data", rd_data, 64'd0);
    chk("t6_araddr", m_axi_araddr, 64'd0);
    chk("t6_arlen", m_axi_arlen, 64'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    cfg_base = 64'h500;
    start(30'h20, 8'd1);
    chk("t6_new_araddr", m_axi_araddr, 64'h20);
    chk("t6_new_arlen", m_axi_arlen, 64'd1);
    wait_done(64'h500, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
